// File: rtl/icache_pkg.sv
// Shared instruction-cache geometry, refill FSM states and address field helpers
// used by the refill controller, the cache array and the fetch stage.
package icache_pkg;

    localparam int OFFSET_WIDTH = 2;
    localparam int LINE_WIDTH   = 6;
    localparam int TAG_WIDTH    = 32 - OFFSET_WIDTH - LINE_WIDTH - 2;
    localparam int BLOCK_SIZE   = 1 << OFFSET_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RECV  = 2'd2,
        WRITE = 2'd3
    } refill_state_t;

    function automatic logic [TAG_WIDTH-1:0] tag_of(input logic [31:0] addr);
        return addr[31:LINE_WIDTH+OFFSET_WIDTH+2];
    endfunction

    function automatic logic [LINE_WIDTH-1:0] line_of(input logic [31:0] addr);
        return addr[LINE_WIDTH+OFFSET_WIDTH+1:OFFSET_WIDTH+2];
    endfunction

    // Byte offset and word offset are both dropped: refills always start at the block base.
    function automatic logic [31:0] block_base_of(input logic [31:0] addr);
        return {addr[31:OFFSET_WIDTH+2], {(OFFSET_WIDTH+2){1'b0}}};
    endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// BLOCK_SIZE x 32-bit word buffer filled one beat at a time and exposed as a
// flat vector with word 0 in the least significant bits.
module refill_line_buffer
    import icache_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_wr_en,
    input  logic [OFFSET_WIDTH-1:0]   i_wr_idx,
    input  logic [31:0]               i_wr_data,
    output logic [32*BLOCK_SIZE-1:0]  o_block
);

    logic [31:0] r_words [BLOCK_SIZE];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                r_words[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_words[i_wr_idx] <= i_wr_data;
        end
    end

    for (genvar j = 0; j < BLOCK_SIZE; j++) begin : g_flat
        assign o_block[32*j +: 32] = r_words[j];
    end

endmodule

// File: rtl/icache_refill_controller.sv
// Instruction-cache miss handler: one block read per miss, beats gathered into a
// line buffer, then a single-cycle write of block, line index and tag.
module icache_refill_controller
    import icache_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      miss_valid,
    input  logic [31:0]               miss_address,
    output logic                      miss_ready,
    output logic                      mem_req_valid,
    output logic [31:0]               mem_req_address,
    input  logic                      mem_req_ready,
    input  logic                      mem_resp_valid,
    input  logic [31:0]               mem_resp_data,
    output logic                      mem_resp_ready,
    output logic                      write_in,
    output logic [LINE_WIDTH-1:0]     write_line_index,
    output logic [32*BLOCK_SIZE-1:0]  write_block,
    output logic [TAG_WIDTH-1:0]      write_tag,
    output logic                      refill_done
);

    refill_state_t             r_state;
    logic [OFFSET_WIDTH-1:0]   r_cnt;
    logic [31:0]               r_addr;
    logic                      r_miss_ready;
    logic                      r_req_valid;
    logic                      r_resp_ready;
    logic                      r_write;
    logic                      w_beat;
    logic                      w_unused_offset;

    assign w_beat = r_resp_ready & mem_resp_valid;

    // miss_ready rises on the first edge after reset release and on leaving WRITE,
    // so it can never coincide with the write strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_miss_ready <= 1'b0;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
            r_write      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_miss_ready <= 1'b1;
                    if (miss_valid && r_miss_ready) begin
                        r_addr       <= miss_address;
                        r_miss_ready <= 1'b0;
                        r_req_valid  <= 1'b1;
                        r_state      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid  <= 1'b0;
                        r_resp_ready <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= RECV;
                    end
                end
                RECV: begin
                    if (mem_resp_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == OFFSET_WIDTH'(BLOCK_SIZE - 1)) begin
                            r_resp_ready <= 1'b0;
                            r_write      <= 1'b1;
                            r_state      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    r_write      <= 1'b0;
                    r_miss_ready <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    refill_line_buffer u_line_buffer (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (w_beat),
        .i_wr_idx  (r_cnt),
        .i_wr_data (mem_resp_data),
        .o_block   (write_block)
    );

    assign w_unused_offset  = ^r_addr[OFFSET_WIDTH+1:0];

    assign miss_ready       = r_miss_ready;
    assign mem_req_valid    = r_req_valid;
    assign mem_req_address  = block_base_of(r_addr);
    assign mem_resp_ready   = r_resp_ready;
    assign write_in         = r_write;
    assign refill_done      = r_write;
    assign write_line_index = line_of(r_addr);
    assign write_tag        = tag_of(r_addr);

endmodule

// File: tb/tb_icache_refill_controller.sv
// Directed bench for the refill controller: a transaction-level model checked
// every cycle plus literal expectations at the key cycles of each scenario.
module tb_icache_refill_controller;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         miss_valid = 1'b0;
    logic [31:0]  miss_address = '0;
    logic         miss_ready;
    logic         mem_req_valid;
    logic [31:0]  mem_req_address;
    logic         mem_req_ready = 1'b0;
    logic         mem_resp_valid = 1'b0;
    logic [31:0]  mem_resp_data = '0;
    logic         mem_resp_ready;
    logic         write_in;
    logic [5:0]   write_line_index;
    logic [127:0] write_block;
    logic [21:0]  write_tag;
    logic         refill_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    icache_refill_controller dut (
        .clock            (clock),
        .reset            (reset),
        .miss_valid       (miss_valid),
        .miss_address     (miss_address),
        .miss_ready       (miss_ready),
        .mem_req_valid    (mem_req_valid),
        .mem_req_address  (mem_req_address),
        .mem_req_ready    (mem_req_ready),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .mem_resp_ready   (mem_resp_ready),
        .write_in         (write_in),
        .write_line_index (write_line_index),
        .write_block      (write_block),
        .write_tag        (write_tag),
        .refill_done      (refill_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: a miss is outstanding from acceptance until its write cycle ends;
    // within it the request is pending until handshaken, then beats are collected.
    bit          m_live, m_out, m_reqd, m_wr;
    int          m_n;
    logic [31:0] m_addr;
    logic [31:0] m_words [4];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_live = 0; m_out = 0; m_reqd = 0; m_wr = 0; m_n = 0; m_addr = '0;
            for (int i = 0; i < 4; i++) m_words[i] = '0;
        end else begin
            if (m_wr) begin
                m_wr = 0;
                m_out = 0;
            end else if (!m_out) begin
                if (m_live && miss_valid) begin
                    m_out = 1; m_reqd = 0; m_n = 0; m_addr = miss_address;
                end
            end else if (!m_reqd) begin
                if (mem_req_ready) m_reqd = 1;
            end else if (mem_resp_valid) begin
                m_words[m_n] = mem_resp_data;
                m_n++;
                if (m_n == 4) m_wr = 1;
            end
            m_live = 1;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model miss_ready", miss_ready, m_live && !m_out);
            chk("model mem_req_valid", mem_req_valid, m_out && !m_reqd);
            chk("model mem_req_address", mem_req_address, m_addr & 32'hFFFF_FFF0);
            chk("model mem_resp_ready", mem_resp_ready, m_out && m_reqd && !m_wr);
            chk("model write_in", write_in, m_wr);
            chk("model refill_done", refill_done, m_wr);
            chk("model line", write_line_index, (m_addr / 16) % 64);
            chk("model tag", write_tag, m_addr / 1024);
            chk("model block", write_block, {m_words[3], m_words[2], m_words[1], m_words[0]});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic beats(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = base + i;
            step();
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    initial begin
        chk_en = 1'b1;
        #2;
        chk("reset miss_ready", miss_ready, 0);
        chk("reset block", write_block, 0);
        step(); step();
        reset = 1'b1;
        step();
        chk("idle miss_ready", miss_ready, 1);

        // Basic refill
        miss_valid = 1'b1; miss_address = 32'h8000_1234; mem_req_ready = 1'b1;
        step();
        miss_valid = 1'b0;
        chk("t1 req_valid c1", mem_req_valid, 1);
        chk("t1 req_addr", mem_req_address, 32'h8000_1230);
        step();
        beats(32'hA0);
        chk("t1 write_in c6", write_in, 1);
        chk("t1 done c6", refill_done, 1);
        chk("t1 miss_ready c6", miss_ready, 0);
        chk("t1 line", write_line_index, 6'h23);
        chk("t1 tag", write_tag, 22'h200004);
        chk("t1 block", write_block, 128'h000000A3_000000A2_000000A1_000000A0);
        step();
        chk("t1 write_in c7", write_in, 0);
        chk("t1 miss_ready c7", miss_ready, 1);

        // Request backpressure with a stray beat during REQ
        mem_req_ready = 1'b0;
        miss_valid = 1'b1; miss_address = 32'h1234_5678;
        step();
        miss_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD;
        for (int c = 0; c < 3; c++) begin
            chk("t2 req_valid held", mem_req_valid, 1);
            chk("t2 req_addr held", mem_req_address, 32'h1234_5670);
            chk("t2 resp_ready low", mem_resp_ready, 0);
            step();
        end
        mem_req_ready = 1'b1;
        mem_resp_valid = 1'b0;
        step();
        mem_req_ready = 1'b0;
        beats(32'hB0);
        chk("t2 write_in", write_in, 1);
        chk("t2 line", write_line_index, 6'h27);
        chk("t2 tag", write_tag, 22'h048D15);
        chk("t2 block", write_block, 128'h000000B3_000000B2_000000B1_000000B0);
        step();

        // Gapped response: beats in cycles 2, 5, 6, 10
        mem_req_ready = 1'b1;
        miss_valid = 1'b1; miss_address = 32'h0000_0ABC;
        step();
        miss_valid = 1'b0;
        step();
        begin
            logic [8:0] pat;
            int k;
            pat = 9'b1_0001_1001;
            k = 0;
            for (int c = 2; c <= 10; c++) begin
                mem_resp_valid = pat[c-2];
                mem_resp_data  = pat[c-2] ? 32'hC0 + k : 32'h0BAD;
                if (pat[c-2]) k++;
                chk("t3 no early write", write_in, 0);
                step();
            end
        end
        mem_resp_valid = 1'b0;
        chk("t3 write_in c11", write_in, 1);
        chk("t3 line", write_line_index, 6'h2B);
        chk("t3 tag", write_tag, 22'h2);
        chk("t3 block", write_block, 128'h000000C3_000000C2_000000C1_000000C0);
        step();

        // Back-to-back misses with miss_valid held high
        miss_valid = 1'b1; miss_address = 32'h0000_0040;
        step();
        miss_address = 32'h0000_03F0;
        chk("t4 busy miss_ready", miss_ready, 0);
        step();
        beats(32'hD0);
        chk("t4 first write", write_in, 1);
        chk("t4 first line", write_line_index, 6'h04);
        chk("t4 first block", write_block, 128'h000000D3_000000D2_000000D1_000000D0);
        chk("t4 no ready in write", miss_ready, 0);
        step();
        chk("t4 ready after write", miss_ready, 1);
        step();
        miss_valid = 1'b0;
        chk("t4 second req", mem_req_address, 32'h0000_03F0);
        step();
        beats(32'hE0);
        chk("t4 second write", write_in, 1);
        chk("t4 second line", write_line_index, 6'h3F);
        chk("t4 second tag", write_tag, 22'h0);
        step();

        // Reset in the middle of collecting beats
        miss_valid = 1'b1; miss_address = 32'h0000_5550;
        step();
        miss_valid = 1'b0;
        step();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h11; step();
        mem_resp_data = 32'h22; step();
        mem_resp_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("t5 async resp_ready", mem_resp_ready, 0);
        chk("t5 async miss_ready", miss_ready, 0);
        chk("t5 async write_in", write_in, 0);
        chk("t5 async addr", mem_req_address, 0);
        chk("t5 async block", write_block, 0);
        step(); step();
        reset = 1'b1;
        step();
        chk("t5 ready after release", miss_ready, 1);
        miss_valid = 1'b1; miss_address = 32'h8000_1234;
        step();
        miss_valid = 1'b0;
        step();
        beats(32'hF0);
        chk("t5 fresh write", write_in, 1);
        chk("t5 fresh block", write_block, 128'h000000F3_000000F2_000000F1_000000F0);
        step(); step();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
